// File: rtl/load_pkg.sv
// Shared types and sizing helpers for the ping-pong image loader.
//   DATA_W_DEF / PIXELS_DEF : default beat width and image size
//   bank_state_e            : per-bank occupancy state
//   calc_beats()            : beats needed to cover one image
package load_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned PIXELS_DEF = 784;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_state_e;

    // Ceiling division: the last beat may be only partly used.
    function automatic int unsigned calc_beats(input int unsigned pixels,
                                               input int unsigned data_w);
        return (pixels + data_w - 1) / data_w;
    endfunction

endpackage

// File: rtl/load_bank.sv
// One image bank: PIXELS x 1 bit, written one beat (DATA_W pixels) at a time,
// read one pixel at a time through a registered output.
//   we / beat_idx / wdata : write beat beat_idx; pixel beat_idx*DATA_W+j <= wdata[j]
//   rd_en / rd_addr       : registered read; rd_bit is 0 when rd_en was low
module load_bank #(
    parameter  int unsigned DATA_W = 8,
    parameter  int unsigned PIXELS = 784,
    parameter  int unsigned BEAT_W = 7,
    localparam int unsigned ADDR_W = $clog2(PIXELS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [BEAT_W-1:0] beat_idx,
    input  logic [DATA_W-1:0] wdata,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_bit
);

    logic [PIXELS-1:0] mem_q, mem_d;
    logic              q_q, q_d;

    // Beat write: each pixel knows its own beat and lane, so bits past
    // PIXELS in the final beat simply have no storage to land in.
    always_comb begin
        mem_d = mem_q;
        for (int unsigned p = 0; p < PIXELS; p++) begin
            if (we && (beat_idx == BEAT_W'(p / DATA_W))) begin
                mem_d[p] = wdata[p % DATA_W];
            end
        end
    end

    // Gated read; the owner only enables it for in-range addresses.
    always_comb begin
        q_d = 1'b0;
        if (rd_en) begin
            q_d = mem_q[rd_addr];
        end
    end

    // Image storage is intentionally not reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign rd_bit = q_q;

endmodule

// File: rtl/load_input_pingpong.sv
// Ping-pong image loader: beats of DATA_W pixels fill one bank while the
// consumer reads the other. Build option LOAD_OVERRUN_DET_EN adds the
// overrun pulse output for dropped triggers.
//   trigger / data : one beat per strobe, LSB = lowest pixel
//   rd_addr / q    : 1-cycle registered pixel read of the read bank
//   ready          : read bank holds a complete image
//   done           : consumer releases the read bank
//   overrun        : (LOAD_OVERRUN_DET_EN only) pulse after a dropped trigger
module load_input_pingpong #(
    parameter  int unsigned DATA_W = load_pkg::DATA_W_DEF,
    parameter  int unsigned PIXELS = load_pkg::PIXELS_DEF,
    localparam int unsigned ADDR_W = $clog2(PIXELS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              trigger,
    input  logic [DATA_W-1:0] data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              q,
    output logic              ready,
    input  logic              done
`ifdef LOAD_OVERRUN_DET_EN
    ,
    output logic              overrun
`endif
);
    import load_pkg::*;

    localparam int unsigned BEATS  = calc_beats(PIXELS, DATA_W);
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    bank_state_e       state_q [2];
    bank_state_e       state_d [2];
    logic              wbank_q, wbank_d;
    logic              rbank_q, rbank_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              ready_q, ready_d;

    logic accept_c, last_c, release_c, in_range_c;
    logic we_c    [2];
    logic rd_en_c [2];
    logic rd_bit  [2];

    // Bank state machine, pointers and beat counter.
    always_comb begin
        state_d    = state_q;
        wbank_d    = wbank_q;
        rbank_d    = rbank_q;
        beat_d     = beat_q;

        accept_c   = trigger && (state_q[wbank_q] != FULL);
        last_c     = (beat_q == BEAT_W'(BEATS - 1));
        release_c  = done && ready_q;
        in_range_c = (32'(rd_addr) < PIXELS);

        we_c[0]    = accept_c && !wbank_q;
        we_c[1]    = accept_c &&  wbank_q;
        rd_en_c[0] = ready_q && in_range_c && !rbank_q;
        rd_en_c[1] = ready_q && in_range_c &&  rbank_q;

        if (accept_c) begin
            if (last_c) begin
                state_d[wbank_q] = FULL;
                beat_d           = '0;
                wbank_d          = ~wbank_q;
            end else begin
                state_d[wbank_q] = FILLING;
                beat_d           = beat_q + BEAT_W'(1);
            end
        end

        // Release targets a FULL bank, accept a non-FULL one: never the same bank.
        if (release_c) begin
            state_d[rbank_q] = EMPTY;
            rbank_d          = ~rbank_q;
        end

        ready_d = (state_d[rbank_d] == FULL);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q[0] <= EMPTY;
            state_q[1] <= EMPTY;
            wbank_q    <= 1'b0;
            rbank_q    <= 1'b0;
            beat_q     <= '0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wbank_q    <= wbank_d;
            rbank_q    <= rbank_d;
            beat_q     <= beat_d;
            ready_q    <= ready_d;
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_bank
        load_bank #(
            .DATA_W (DATA_W),
            .PIXELS (PIXELS),
            .BEAT_W (BEAT_W)
        ) u_bank (
            .clk      (clk),
            .rst_n    (rst_n),
            .we       (we_c[i]),
            .beat_idx (beat_q),
            .wdata    (data),
            .rd_en    (rd_en_c[i]),
            .rd_addr  (rd_addr),
            .rd_bit   (rd_bit[i])
        );
    end

    // At most one bank read is enabled, so OR-ing the registered bits is a mux.
    assign q     = rd_bit[0] | rd_bit[1];
    assign ready = ready_q;

`ifdef LOAD_OVERRUN_DET_EN
    logic overrun_q, overrun_d;

    always_comb begin
        overrun_d = trigger && !accept_c;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign overrun = overrun_q;
`endif

endmodule

// File: tb/tb_load_input_pingpong.sv
// Bench for load_input_pingpong: directed scenarios plus random traffic,
// checked every cycle against a queue-of-images model, and a small
// 20-pixel instance checked with directed expectations.
module tb_load_input_pingpong;

    localparam int PIX = 784;
    localparam int BW  = 8;
    localparam int NB  = (PIX + BW - 1) / BW;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       trigger, done, q, ready;
    logic [7:0] data;
    logic [9:0] rd_addr;
    logic       overrun;

    logic       s_trigger, s_done, s_q, s_ready;
    logic [7:0] s_data;
    logic [4:0] s_addr;
    logic       s_overrun;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    load_input_pingpong #(.DATA_W(8), .PIXELS(784)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .trigger (trigger),
        .data    (data),
        .rd_addr (rd_addr),
        .q       (q),
        .ready   (ready),
        .done    (done)
`ifdef LOAD_OVERRUN_DET_EN
        ,
        .overrun (overrun)
`endif
    );

    load_input_pingpong #(.DATA_W(8), .PIXELS(20)) dut_s (
        .clk     (clk),
        .rst_n   (rst_n),
        .trigger (s_trigger),
        .data    (s_data),
        .rd_addr (s_addr),
        .q       (s_q),
        .ready   (s_ready),
        .done    (s_done)
`ifdef LOAD_OVERRUN_DET_EN
        ,
        .overrun (s_overrun)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: completed images wait in a 2-deep FIFO; the partial image is
    // assembled separately and discarded by reset.
    logic [PIX-1:0] imgs[$];
    logic [PIX-1:0] part;
    int             part_beats = 0;
    int             m_n;
    logic           exp_q = 1'b0, exp_ready = 1'b0, exp_ovr = 1'b0;
    logic           armed = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            armed      = 1'b1;
            imgs.delete();
            part_beats = 0;
            exp_q      = 1'b0;
            exp_ready  = 1'b0;
            exp_ovr    = 1'b0;
        end else begin
            m_n     = imgs.size();
            exp_q   = (m_n > 0 && int'(rd_addr) < PIX) ? imgs[0][rd_addr] : 1'b0;
            exp_ovr = trigger && (m_n == 2);
            if (trigger && m_n < 2) begin
                for (int j = 0; j < BW; j++) begin
                    if (part_beats * BW + j < PIX) part[part_beats * BW + j] = data[j];
                end
                part_beats++;
                if (part_beats == NB) begin
                    imgs.push_back(part);
                    part_beats = 0;
                end
            end
            if (done && m_n > 0) void'(imgs.pop_front());
            exp_ready = (imgs.size() > 0);
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("model_q", 32'(q), 32'(exp_q));
            chk("model_ready", 32'(ready), 32'(exp_ready));
`ifdef LOAD_OVERRUN_DET_EN
            chk("model_overrun", 32'(overrun), 32'(exp_ovr));
`endif
        end
    end

    task automatic cyc(input logic t, input logic [7:0] d, input logic dn, input logic [9:0] a);
        trigger = t;
        data    = d;
        done    = dn;
        rd_addr = a;
        @(negedge clk);
    endtask

    function automatic logic [9:0] raddr();
        return 10'($urandom_range(0, 799));
    endfunction

    function automatic logic [9:0] iaddr();
        return 10'($urandom_range(0, PIX - 1));
    endfunction

    logic [7:0] pat;
    logic [7:0] sb [3];
    logic [9:0] a;
    logic       e;

    initial begin
        rst_n = 1'b0;
        trigger = 1'b0; data = '0; done = 1'b0; rd_addr = '0;
        s_trigger = 1'b0; s_data = '0; s_done = 1'b0; s_addr = '0;
        repeat (3) @(negedge clk);
        chk("reset_ready", 32'(ready), 32'(0));
        chk("reset_q", 32'(q), 32'(0));
`ifdef LOAD_OVERRUN_DET_EN
        chk("reset_overrun", 32'(overrun), 32'(0));
`endif
        rst_n = 1'b1;

        // Small instance: 3 beats, upper nibble of beat 2 has nowhere to go.
        sb[0] = 8'h12; sb[1] = 8'h34; sb[2] = 8'hF6;
        for (int k = 0; k < 3; k++) begin
            s_trigger = 1'b1; s_data = sb[k];
            @(negedge clk);
            chk("small_ready", 32'(s_ready), 32'(k == 2));
        end
        s_trigger = 1'b0;
        for (int i = 0; i <= 20; i++) begin
            s_addr = 5'(i);
            @(negedge clk);
            e = (i < 20) ? sb[i / 8][i % 8] : 1'b0;
            chk("small_q", 32'(s_q), 32'(e));
        end
`ifdef LOAD_OVERRUN_DET_EN
        chk("small_overrun", 32'(s_overrun), 32'(0));
`endif

        // Image of 0xA5: ready only after the last beat.
        for (int k = 0; k < NB; k++) begin
            cyc(1'b1, 8'hA5, 1'b0, raddr());
            chk("s1_ready", 32'(ready), 32'(k == NB - 1));
        end
        pat = 8'hA5;
        for (int i = 0; i < PIX; i++) begin
            cyc(1'b0, 8'h00, 1'b0, 10'(i));
            chk("s1_q", 32'(q), 32'(pat[i % 8]));
        end
        cyc(1'b0, 8'h00, 1'b0, 10'(PIX));
        chk("s1_q_oob", 32'(q), 32'(0));

        // Load 0xFF into bank 1 while bank 0 is read.
        for (int k = 0; k < NB; k++) begin
            a = raddr();
            cyc(1'b1, 8'hFF, 1'b0, a);
            chk("s2_ready", 32'(ready), 32'(1));
            chk("s2_q", 32'(q), 32'((int'(a) < PIX) ? pat[a % 8] : 1'b0));
        end
        cyc(1'b0, 8'h00, 1'b1, 10'd0);
        chk("s2_ready_after_done", 32'(ready), 32'(1));
        for (int i = 0; i < 40; i++) begin
            cyc(1'b0, 8'h00, 1'b0, iaddr());
            chk("s2_q_ones", 32'(q), 32'(1));
        end

        // Fill bank 0 with 0x3C, then one extra trigger must be dropped.
        for (int k = 0; k < NB; k++) cyc(1'b1, 8'h3C, 1'b0, raddr());
        cyc(1'b1, 8'h99, 1'b0, 10'd5);
        chk("s3_q_bank1", 32'(q), 32'(1));
`ifdef LOAD_OVERRUN_DET_EN
        chk("s3_overrun_pulse", 32'(overrun), 32'(1));
`endif
        cyc(1'b0, 8'h00, 1'b0, 10'd7);
`ifdef LOAD_OVERRUN_DET_EN
        chk("s3_overrun_clear", 32'(overrun), 32'(0));
`endif
        chk("s3_q_bank1b", 32'(q), 32'(1));
        cyc(1'b0, 8'h00, 1'b1, 10'd0);
        chk("s3_ready", 32'(ready), 32'(1));
        pat = 8'h3C;
        for (int i = 0; i < 24; i++) begin
            a = (i < 8) ? 10'(i) : iaddr();
            cyc(1'b0, 8'h00, 1'b0, a);
            chk("s3_q_bank0", 32'(q), 32'(pat[a % 8]));
        end

        // Final beat of bank 1 coincides with done on bank 0.
        for (int k = 0; k < NB - 1; k++) cyc(1'b1, 8'($urandom), 1'b0, raddr());
        cyc(1'b1, 8'($urandom), 1'b1, 10'd0);
        chk("s4_ready", 32'(ready), 32'(1));
        for (int i = 0; i < 30; i++) cyc(1'b0, 8'h00, 1'b0, raddr());

        // Reset in the middle of loading bank 0.
        for (int k = 0; k < 50; k++) cyc(1'b1, 8'($urandom), 1'b0, raddr());
        rst_n = 1'b0;
        cyc(1'b0, 8'h00, 1'b0, 10'd0);
        chk("s5_ready_reset", 32'(ready), 32'(0));
        chk("s5_q_reset", 32'(q), 32'(0));
        rst_n = 1'b1;
        for (int k = 0; k < NB; k++) begin
            cyc(1'b1, 8'h0F, 1'b0, raddr());
            chk("s5_ready", 32'(ready), 32'(k == NB - 1));
        end
        pat = 8'h0F;
        for (int i = 0; i < PIX; i++) begin
            cyc(1'b0, 8'h00, 1'b0, 10'(i));
            chk("s5_q", 32'(q), 32'(pat[i % 8]));
        end

        // Random traffic, including ignored dones and rare resets.
        for (int c = 0; c < 4000; c++) begin
            rst_n = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
            cyc(1'($urandom_range(0, 9) < 7), 8'($urandom),
                1'($urandom_range(0, 19) == 0), raddr());
        end
        rst_n = 1'b1;
        cyc(1'b0, 8'h00, 1'b0, 10'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/load_input_pingpong.md
LOAD_INPUT_PINGPONG -- requirements
Module: load_input_pingpong

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the bits delivered per trigger beat.
REQ-002 Parameter PIXELS, default 784, SHALL set the number of 1-bit pixels per image.
REQ-003 Derived constants SHALL be ADDR_W = clog2(PIXELS), which is 10 by default, and BEATS = ceil(PIXELS/DATA_W), which is 98 by default.
REQ-004 clk  in  1  single clock; all state SHALL change on its rising edge.
REQ-005 rst_n  in  1  synchronous, active-low reset.
REQ-006 trigger  in  1  one-cycle strobe; data is valid in the same cycle.
REQ-007 data  in  DATA_W  pixel beat, LSB first.
REQ-008 rd_addr  in  ADDR_W  pixel read address into the read bank.
REQ-009 q  out  1  registered pixel value at rd_addr.
REQ-010 ready  out  1  the read bank holds a complete image.
REQ-011 done  in  1  consumer pulse that releases the read bank.
REQ-012 overrun  out  1  one-cycle pulse when a trigger is dropped; present only with the macro in REQ-032.

Function
REQ-013 The block SHALL hold two banks, 0 and 1, each PIXELS x 1 bit, used as a ping-pong pair with a write pointer wbank and a read pointer rbank.
REQ-014 Each bank SHALL be in one of three states: EMPTY, FILLING or FULL.
REQ-015 Bank state transitions SHALL be:
- EMPTY -> FILLING on the first accepted trigger;
- FILLING -> FULL on the accepted beat number BEATS-1;
- FULL -> EMPTY on done while that bank is rbank.
REQ-016 A beat counter, 0..BEATS-1, SHALL increment on each accepted trigger and wrap to 0 after beat BEATS-1, in the same cycle wbank toggles.
REQ-017 Beat k, bit j SHALL write pixel k*DATA_W+j of bank wbank; bits whose index is PIXELS or greater SHALL be discarded.
REQ-018 A trigger SHALL be accepted only while bank wbank is EMPTY or FILLING; otherwise it SHALL be dropped with no state change.
REQ-019 ready SHALL be 1 exactly while bank rbank is FULL, and SHALL rise in the cycle after the final beat is accepted.
REQ-020 Read latency SHALL be 1 cycle: q = bank[rbank][rd_addr] sampled at the previous edge; q SHALL be 0 when rd_addr >= PIXELS or when ready was 0.
REQ-021 done while ready is 1 SHALL set bank rbank to EMPTY and toggle rbank; ready SHALL fall in the next cycle unless the other bank is already FULL.
REQ-022 done while ready is 0 SHALL be ignored.
REQ-023 A final beat and done in the same cycle SHALL both take effect.
REQ-024 If rbank = wbank, the final beat and done land on the same bank and never coincide, because done requires FULL.
REQ-025 Loading into one bank SHALL proceed unaffected while the other bank is being read.

Reset
REQ-026 While rst_n is 0 at a clock edge:
- wbank = 0, rbank = 0;
- both banks EMPTY;
- beat counter = 0;
- q = 0, ready = 0, overrun = 0.
REQ-027 Reset during a load SHALL discard the partial image; memory contents need not be cleared.
REQ-028 The first accepted trigger after reset SHALL be beat 0 of bank 0.

Configuration
REQ-029 With LOAD_OVERRUN_DET_EN defined, overrun SHALL pulse high for 1 cycle, in the cycle after each dropped trigger.
REQ-030 Without LOAD_OVERRUN_DET_EN, the overrun port SHALL be absent and dropped triggers SHALL be silent.
REQ-031 The macro SHALL not change any other behaviour.
REQ-032 The macro name SHALL be LOAD_OVERRUN_DET_EN.

Structure
REQ-033 Package load_pkg SHALL hold:
- default DATA_W and PIXELS;
- the bank-state enum (EMPTY, FILLING, FULL);
- the BEATS calculation function.
REQ-034 Sub-module load_bank SHALL implement one bank: beat-wide write at a beat index, and a 1-bit registered read.
REQ-035 load_bank SHALL be instantiated twice; the top SHALL hold the pointers, counters and state.

Verification
REQ-036 The bench SHALL cover these directed scenarios:
- Reset, then 98 triggers of 8'hA5 (defaults) -> ready stays 0 through beat 97, rises the next cycle, no earlier; reading addr 0..783 gives q = 1,0,1,0,0,1,0,1 repeating, 1 cycle late.
- Second image of 8'hFF loaded while bank 0 is read -> ready stays 1 and bank 0 data is intact; after done, ready stays 1 and reads give all 1s.
- Both banks FULL plus one more trigger -> trigger dropped; overrun = 1 for one cycle (macro on) and both images unchanged.
- Final beat of bank 1 and done on bank 0 in the same cycle -> rbank = 1, ready remains 1, no data loss.
- rst_n low at beat 50 -> ready = 0; next 98 beats of 8'h0F load bank 0 correctly.
- PIXELS = 20, DATA_W = 8 -> BEATS = 3, upper 4 bits of beat 2 discarded; rd_addr = 20 gives q = 0.
